// File: rtl/powlib_sfifo_pkg.sv
// Shared helpers for the powlib single-clock FIFO.
// Constant functions for pointer sizing and non-power-of-2 wrap.
package powlib_sfifo_pkg;

    function automatic int powlib_clogb2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int powlib_wrapinc(input int ptr, input int d);
        return (ptr == d - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/powlib_dpram.sv
// Simple dual-port RAM: one synchronous write port, one async read port.
// EWBE=1 enables per-bit write enables; storage is never reset.
module powlib_dpram #(
    parameter int W    = 16,
    parameter int D    = 8,
    parameter int EWBE = 0,
    parameter int WIDX = 3
) (
    input  logic            clk,
    input  logic [WIDX-1:0] wridx,
    input  logic [W-1:0]    wrdata,
    input  logic [W-1:0]    wrbe,
    input  logic            wrvld,
    input  logic [WIDX-1:0] rdidx,
    output logic [W-1:0]    rddata
);

    logic [W-1:0] mem_q [D];
    logic [W-1:0] wrword;

    always_comb begin
        wrword = wrdata;
        if (EWBE != 0) begin
            wrword = (mem_q[wridx] & ~wrbe) | (wrdata & wrbe);
        end
    end

    always_ff @(posedge clk) begin
        if (wrvld) begin
            mem_q[wridx] <= wrword;
        end
    end

    assign rddata = mem_q[rdidx];

endmodule

// File: rtl/powlib_sfifo.sv
// Single-clock FWFT FIFO with valid/ready on both sides, occupancy and flush.
// Define POWLIB_SFIFO_ERR_EN to add sticky ovfl/udfl error outputs.
module powlib_sfifo
    import powlib_sfifo_pkg::*;
#(
    parameter int W    = 16,
    parameter int D    = 8,
    parameter int AFT  = D - 2,
    parameter int WIDX = powlib_clogb2(D),
    parameter int WCNT = powlib_clogb2(D + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [W-1:0]    wrdata,
    input  logic            wrvld,
    output logic            wrrdy,
    output logic [W-1:0]    rddata,
    output logic            rdvld,
    input  logic            rdrdy,
    output logic [WCNT-1:0] cnt,
    output logic            afull
`ifdef POWLIB_SFIFO_ERR_EN
    ,
    output logic            ovfl,
    output logic            udfl
`endif
);

    logic [WIDX-1:0] wrptr_q, wrptr_d;
    logic [WIDX-1:0] rdptr_q, rdptr_d;
    logic [WCNT-1:0] cnt_q, cnt_d;
    logic            wr_fire;
    logic            rd_fire;

    assign wrrdy = (cnt_q != WCNT'(D));
    assign rdvld = (cnt_q != '0);
    assign afull = (cnt_q >= WCNT'(AFT));
    assign cnt   = cnt_q;

    // A flushed cycle's write must not reach storage either.
    assign wr_fire = wrvld & wrrdy & ~clr;
    assign rd_fire = rdvld & rdrdy & ~clr;

    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        cnt_d   = cnt_q;
        if (clr) begin
            wrptr_d = '0;
            rdptr_d = '0;
            cnt_d   = '0;
        end else begin
            if (wr_fire) begin
                wrptr_d = WIDX'(powlib_wrapinc(int'(wrptr_q), D));
            end
            if (rd_fire) begin
                rdptr_d = WIDX'(powlib_wrapinc(int'(rdptr_q), D));
            end
            if (wr_fire && !rd_fire) begin
                cnt_d = cnt_q + WCNT'(1);
            end else if (rd_fire && !wr_fire) begin
                cnt_d = cnt_q - WCNT'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            cnt_q   <= '0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            cnt_q   <= cnt_d;
        end
    end

    powlib_dpram #(
        .W    (W),
        .D    (D),
        .EWBE (0),
        .WIDX (WIDX)
    ) u_ram (
        .clk    (clk),
        .wridx  (wrptr_q),
        .wrdata (wrdata),
        .wrbe   ({W{1'b1}}),
        .wrvld  (wr_fire),
        .rdidx  (rdptr_q),
        .rddata (rddata)
    );

`ifdef POWLIB_SFIFO_ERR_EN
    logic ovfl_q, ovfl_d;
    logic udfl_q, udfl_d;

    always_comb begin
        ovfl_d = ovfl_q | (wrvld & ~wrrdy);
        udfl_d = udfl_q | (rdrdy & ~rdvld);
        if (clr) begin
            ovfl_d = 1'b0;
            udfl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovfl_q <= 1'b0;
            udfl_q <= 1'b0;
        end else begin
            ovfl_q <= ovfl_d;
            udfl_q <= udfl_d;
        end
    end

    assign ovfl = ovfl_q;
    assign udfl = udfl_q;
`endif

endmodule

// File: tb/tb_powlib_sfifo.sv
// Bench for powlib_sfifo: queue model checked every cycle on D=8 and D=5
// instances, plus hand-computed checks of the directed scenarios.
module tb_powlib_sfifo;

    logic clk;
    logic rst;

    logic        clr8, wrvld8, rdrdy8;
    logic [15:0] wrdata8;
    logic        wrrdy8, rdvld8, afull8;
    logic [15:0] rddata8;
    logic [3:0]  cnt8;

    logic        clr5, wrvld5, rdrdy5;
    logic [15:0] wrdata5;
    logic        wrrdy5, rdvld5, afull5;
    logic [15:0] rddata5;
    logic [2:0]  cnt5;

`ifdef POWLIB_SFIFO_ERR_EN
    logic ovfl8, udfl8, ovfl5, udfl5;
`endif

    int checks;
    int errors;

    powlib_sfifo #(.W(16), .D(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr8),
        .wrdata (wrdata8),
        .wrvld  (wrvld8),
        .wrrdy  (wrrdy8),
        .rddata (rddata8),
        .rdvld  (rdvld8),
        .rdrdy  (rdrdy8),
        .cnt    (cnt8),
        .afull  (afull8)
`ifdef POWLIB_SFIFO_ERR_EN
        ,
        .ovfl   (ovfl8),
        .udfl   (udfl8)
`endif
    );

    powlib_sfifo #(.W(16), .D(5)) u_dut5 (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr5),
        .wrdata (wrdata5),
        .wrvld  (wrvld5),
        .wrrdy  (wrrdy5),
        .rddata (rddata5),
        .rdvld  (rdvld5),
        .rdrdy  (rdrdy5),
        .cnt    (cnt5),
        .afull  (afull5)
`ifdef POWLIB_SFIFO_ERR_EN
        ,
        .ovfl   (ovfl5),
        .udfl   (udfl5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a queue per FIFO, updated from the handshake rules only.
    logic [15:0] q8[$];
    logic [15:0] q5[$];
    bit m_ovfl8, m_udfl8, m_ovfl5, m_udfl5;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q8.delete();
            q5.delete();
            m_ovfl8 = 0; m_udfl8 = 0;
            m_ovfl5 = 0; m_udfl5 = 0;
        end else begin
            begin
                bit w, r;
                w = wrvld8 && (q8.size() < 8);
                r = rdrdy8 && (q8.size() > 0);
                if (clr8) begin
                    q8.delete();
                    m_ovfl8 = 0; m_udfl8 = 0;
                end else begin
                    if (wrvld8 && q8.size() == 8) m_ovfl8 = 1;
                    if (rdrdy8 && q8.size() == 0) m_udfl8 = 1;
                    if (r) void'(q8.pop_front());
                    if (w) q8.push_back(wrdata8);
                end
            end
            begin
                bit w, r;
                w = wrvld5 && (q5.size() < 5);
                r = rdrdy5 && (q5.size() > 0);
                if (clr5) begin
                    q5.delete();
                    m_ovfl5 = 0; m_udfl5 = 0;
                end else begin
                    if (wrvld5 && q5.size() == 5) m_ovfl5 = 1;
                    if (rdrdy5 && q5.size() == 0) m_udfl5 = 1;
                    if (r) void'(q5.pop_front());
                    if (w) q5.push_back(wrdata5);
                end
            end
        end
    end

    logic [15:0] out5[$];
    int max_cnt5;

    always @(negedge clk) begin
        chk("cnt8",   32'(cnt8),   32'(q8.size()));
        chk("rdvld8", 32'(rdvld8), 32'(q8.size() != 0));
        chk("wrrdy8", 32'(wrrdy8), 32'(q8.size() != 8));
        chk("afull8", 32'(afull8), 32'(q8.size() >= 6));
        if (q8.size() != 0) chk("rddata8", 32'(rddata8), 32'(q8[0]));
        chk("cnt5",   32'(cnt5),   32'(q5.size()));
        chk("rdvld5", 32'(rdvld5), 32'(q5.size() != 0));
        chk("wrrdy5", 32'(wrrdy5), 32'(q5.size() != 5));
        chk("afull5", 32'(afull5), 32'(q5.size() >= 3));
        if (q5.size() != 0) chk("rddata5", 32'(rddata5), 32'(q5[0]));
`ifdef POWLIB_SFIFO_ERR_EN
        chk("ovfl8", 32'(ovfl8), 32'(m_ovfl8));
        chk("udfl8", 32'(udfl8), 32'(m_udfl8));
        chk("ovfl5", 32'(ovfl5), 32'(m_ovfl5));
        chk("udfl5", 32'(udfl5), 32'(m_udfl5));
`endif
        if (rdvld5 && rdrdy5) out5.push_back(rddata5);
        if (int'(cnt5) > max_cnt5) max_cnt5 = int'(cnt5);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        max_cnt5 = 0;
        rst = 1'b1;
        clr8 = 0; wrvld8 = 0; rdrdy8 = 0; wrdata8 = '0;
        clr5 = 0; wrvld5 = 0; rdrdy5 = 0; wrdata5 = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst cnt",   32'(cnt8),   32'd0);
        chk("rst rdvld", 32'(rdvld8), 32'd0);
        chk("rst wrrdy", 32'(wrrdy8), 32'd1);
        chk("rst afull", 32'(afull8), 32'd0);

        // Three writes, no reads.
        wrvld8 = 1; wrdata8 = 16'hA1;
        step();
        chk("t1 rdvld",  32'(rdvld8),  32'd1);
        chk("t1 rddata", 32'(rddata8), 32'hA1);
        wrdata8 = 16'hA2;
        step();
        wrdata8 = 16'hA3;
        step();
        chk("t1 cnt",    32'(cnt8),    32'd3);
        chk("t1 head",   32'(rddata8), 32'hA1);

        // Fill to D=8, watching afull turn on at 6.
        for (int i = 4; i <= 8; i++) begin
            wrdata8 = 16'(16'hB0 + i);
            step();
            chk("t2 afull", 32'(afull8), (i >= 6) ? 32'd1 : 32'd0);
        end
        chk("t2 cnt",   32'(cnt8),   32'd8);
        chk("t2 wrrdy", 32'(wrrdy8), 32'd0);
        wrdata8 = 16'hFF;
        step();
        chk("t2 blocked cnt", 32'(cnt8), 32'd8);
`ifdef POWLIB_SFIFO_ERR_EN
        chk("t2 ovfl", 32'(ovfl8), 32'd1);
`endif

        // Full with read and write together: only the read fires.
        rdrdy8 = 1;
        step();
        wrvld8 = 0; rdrdy8 = 0;
        chk("t3 cnt",    32'(cnt8),    32'd7);
        chk("t3 wrrdy",  32'(wrrdy8),  32'd1);
        chk("t3 rddata", 32'(rddata8), 32'hA2);

        // Drain to 4, then flush with a same-cycle write.
        rdrdy8 = 1;
        repeat (3) step();
        rdrdy8 = 0;
        chk("t5 pre cnt", 32'(cnt8), 32'd4);
        clr8 = 1; wrvld8 = 1; wrdata8 = 16'hEE;
        step();
        clr8 = 0; wrvld8 = 0;
        chk("t5 cnt",   32'(cnt8),   32'd0);
        chk("t5 rdvld", 32'(rdvld8), 32'd0);
        step();
        chk("t5 lost",  32'(cnt8),   32'd0);
`ifdef POWLIB_SFIFO_ERR_EN
        chk("t5 ovfl clr", 32'(ovfl8), 32'd0);
        rdrdy8 = 1;
        step();
        rdrdy8 = 0;
        chk("udfl", 32'(udfl8), 32'd1);
`endif

        // D=5 streaming through the wrap point.
        rdrdy5 = 1; wrvld5 = 1;
        for (int i = 0; i < 12; i++) begin
            wrdata5 = 16'(i);
            step();
        end
        wrvld5 = 0;
        step();
        step();
        rdrdy5 = 0;
        chk("t4 count", 32'(out5.size()), 32'd12);
        for (int i = 0; i < out5.size() && i < 12; i++) begin
            chk("t4 order", 32'(out5[i]), 32'(i));
        end
        chk("t4 maxcnt", 32'(max_cnt5 <= 1), 32'd1);

        // Async reset mid-cycle with cnt=3.
        wrvld8 = 1;
        for (int i = 0; i < 3; i++) begin
            wrdata8 = 16'(16'hC1 + i);
            step();
        end
        wrvld8 = 0;
        chk("t6 pre cnt", 32'(cnt8), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 cnt",   32'(cnt8),   32'd0);
        chk("t6 rdvld", 32'(rdvld8), 32'd0);
        chk("t6 wrrdy", 32'(wrrdy8), 32'd1);
        step();
        rst = 1'b0;
        step();
        chk("t6 after", 32'(cnt8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
